// File: rtl/mcu_port_fifo.sv
// Byte FIFOs between the MCU port interface and the core UART logic, plus the
// packed line-settings status word read by the MCU.
module mcu_port_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  port_out_available,
  input  logic        port_out_strobe,
  output logic [7:0]  port_out_data,
  output logic [7:0]  port_in_available,
  input  logic        port_in_strobe,
  input  logic [7:0]  port_in_data,
  output logic [31:0] port_status,
  input  logic        core_tx_valid,
  input  logic [7:0]  core_tx_data,
  output logic        core_tx_ready,
  output logic        core_rx_valid,
  output logic [7:0]  core_rx_data,
  input  logic        core_rx_ready,
  input  logic [23:0] core_bitrate,
  input  logic [7:0]  core_format,
  output logic [1:0]  overflow,
  input  logic        overflow_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_CNT     = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = DEPTH_LOG2'(1);
  localparam logic [7:0]            IN_AVAIL_RST = (DEPTH > 255) ? 8'hFF : 8'(DEPTH);

  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr, tx_rd, tx_rd_nxt;
  logic [CW-1:0]         tx_count, tx_count_nxt;
  logic                  tx_push, tx_pop, tx_drop;

  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr, rx_rd, rx_rd_nxt;
  logic [CW-1:0]         rx_count, rx_count_nxt;
  logic                  rx_push, rx_pop, rx_drop;

  logic [15:0]           tx_level, rx_free;

  // A pop on a full FIFO frees the slot, so a same-cycle push is still taken.
  always_comb begin
    tx_pop       = port_out_strobe && (tx_count != '0);
    tx_push      = core_tx_valid && ((tx_count != FULL_CNT) || tx_pop);
    tx_drop      = core_tx_valid && !tx_push;
    tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
    tx_rd_nxt    = tx_pop ? tx_rd + PTR_ONE : tx_rd;

    rx_pop       = core_rx_valid && core_rx_ready;
    rx_push      = port_in_strobe && ((rx_count != FULL_CNT) || rx_pop);
    rx_drop      = port_in_strobe && !rx_push;
    rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);
    rx_rd_nxt    = rx_pop ? rx_rd + PTR_ONE : rx_rd;

    tx_level     = 16'(tx_count_nxt);
    rx_free      = 16'(DEPTH) - 16'(rx_count_nxt);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= core_tx_data;
    if (rx_push) rx_mem[rx_wr] <= port_in_data;
  end

  // Status is loaded from the next count so it never disagrees with the
  // stored contents; port_out_available cannot go non-zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr              <= '0;
      tx_rd              <= '0;
      tx_count           <= '0;
      rx_wr              <= '0;
      rx_rd              <= '0;
      rx_count           <= '0;
      port_out_data      <= '0;
      core_rx_data       <= '0;
      port_out_available <= '0;
      port_in_available  <= IN_AVAIL_RST;
      core_tx_ready      <= 1'b1;
      core_rx_valid      <= 1'b0;
      overflow           <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      tx_rd    <= tx_rd_nxt;
      tx_count <= tx_count_nxt;
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      rx_rd    <= rx_rd_nxt;
      rx_count <= rx_count_nxt;

      // Forward the incoming byte when it lands on the new head slot.
      if (tx_count_nxt != '0)
        port_out_data <= (tx_push && (tx_wr == tx_rd_nxt)) ? core_tx_data : tx_mem[tx_rd_nxt];
      if (rx_count_nxt != '0)
        core_rx_data <= (rx_push && (rx_wr == rx_rd_nxt)) ? port_in_data : rx_mem[rx_rd_nxt];

      port_out_available <= (tx_level > 16'd255) ? 8'hFF : tx_level[7:0];
      port_in_available  <= (rx_free > 16'd255) ? 8'hFF : rx_free[7:0];
      core_tx_ready      <= (tx_count_nxt != FULL_CNT);
      core_rx_valid      <= (rx_count_nxt != '0);

      if (overflow_clr) overflow <= '0;
      else              overflow <= overflow | {rx_drop, tx_drop};
    end
  end

  always_ff @(posedge clk) begin
    port_status <= {core_bitrate[7:0], core_bitrate[15:8], core_bitrate[23:16], core_format};
  end

endmodule

// File: doc/mcu_port_fifo.md
Name: mcu_port_fifo

Overview:
- Byte buffer between the system-control port interface (MCU side, serial port index 0) and the core's serial/UART logic.
- Two independent FIFOs:
  - TX: core -> MCU, drained by port_out_strobe.
  - RX: MCU -> core, filled by port_in_strobe.
- Also packs the core's line settings into the 32-bit port_status word that the MCU reads with port subcommand 0.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries); legal range 2..9.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- port_out_available  out  8  TX fill level, saturated at 255
- port_out_strobe  in  1  pop one TX byte (one-cycle pulse)
- port_out_data  out  8  TX head byte, first-word-fall-through
- port_in_available  out  8  RX free entries, saturated at 255
- port_in_strobe  in  1  push port_in_data into RX (one-cycle pulse)
- port_in_data  in  8  byte from MCU
- port_status  out  32  packed bitrate and line format
- core_tx_valid  in  1  core offers byte for MCU
- core_tx_data  in  8  byte from core
- core_tx_ready  out  1  TX not full
- core_rx_valid  out  1  RX not empty
- core_rx_data  out  8  RX head byte, first-word-fall-through
- core_rx_ready  in  1  core consumes RX head
- core_bitrate  in  24  current bitrate in baud
- core_format  in  8  [3:0] data bits, [5:4] parity (0 none, 1 odd, 2 even), [7:6] stop bits code
- overflow  out  2  sticky: [0] TX push while full, [1] RX push while full
- overflow_clr  in  1  clears both overflow bits

Behaviour:
- Each FIFO is a circular buffer of 2^DEPTH_LOG2 bytes with read/write pointers of DEPTH_LOG2 bits and a count of DEPTH_LOG2+1 bits. Pointers wrap modulo depth.
- Reset (synchronous, this cycle):
  - Pointers and counts go to 0.
  - overflow = 0, core_tx_ready = 1, core_rx_valid = 0.
  - port_out_available = 0, port_in_available = min(depth, 255).
  - port_out_data = core_rx_data = 0x00.
  - Reset mid-transfer discards all buffered bytes; no partial state survives.
- TX push: core_tx_valid && core_tx_ready writes core_tx_data at the write pointer.
  - core_tx_valid while full: byte dropped, overflow[0] set.
- TX pop: port_out_strobe while count > 0 advances the read pointer.
  - port_out_strobe while empty: ignored, with no pointer or count change.
- RX push: port_in_strobe while not full writes the byte.
  - port_in_strobe while full: byte dropped, overflow[1] set. The MCU is expected to respect port_in_available.
- RX pop: core_rx_valid && core_rx_ready.
- Simultaneous push and pop on the same FIFO:
  - Count unchanged.
  - On a full FIFO the pop is taken first in the same cycle, so the push is accepted (TX ready is computed from the registered count, so a full TX FIFO still deasserts ready; RX accepts).
  - On an empty FIFO the pushed byte becomes head next cycle. The pop is ignored.
- Head outputs (port_out_data, core_rx_data) are registered and equal mem[rd_ptr] no later than 1 cycle after any pointer or memory change.
  - sysctrl registers port_out_strobe and samples port_out_data one SPI byte later, so a 1-cycle update latency is sufficient.
  - The head holds its last value when the FIFO is empty.
- Status outputs are registered from count and reflect an operation 1 cycle after it:
  - port_out_available = min(tx_count, 255).
  - port_in_available = min(depth - rx_count, 255).
  - core_tx_ready = (tx_count != depth); core_rx_valid = (rx_count != 0).
- port_status is registered every cycle:
  - [31:24] = core_bitrate[7:0]
  - [23:16] = core_bitrate[15:8]
  - [15:8] = core_bitrate[23:16]
  - [7:0] = core_format
- overflow_clr takes priority over a setting event in the same cycle.
- A rising port_out_available from 0 is what triggers the MCU interrupt in sysctrl. This block must therefore never glitch port_out_available non-zero when no byte is stored.

Test Plan:
- Reset check: after reset, port_out_available=0, port_in_available=16, core_tx_ready=1, core_rx_valid=0, overflow=0.
- TX ordering: push 0x11, 0x22, 0x33 from core -> port_out_available=3 and port_out_data=0x11. Three strobes -> data 0x22, 0x33, then available=0. A fourth strobe is ignored, with available staying 0.
- TX full: push 17 bytes 0x00..0x10 -> core_tx_ready=0 after the 16th, overflow[0]=1, and the MCU reads 0x00..0x0F in order. overflow_clr -> overflow=0.
- RX path: three port_in_strobe of 0xA5, 0x5A, 0xFF -> port_in_available=13, core_rx_valid=1, core_rx_data=0xA5. Pop all -> bytes in order, port_in_available=16.
- Simultaneous: TX FIFO at 16 entries with a pop and push in the same cycle -> count stays 16 and the order is preserved. RX empty with a push and pop in the same cycle -> byte retained, core_rx_valid=1.
- Status and reset: core_bitrate=115200 (0x01C200) with format 0x08 -> port_status=0x00C20108. Reset with 5 bytes buffered -> both FIFOs empty the next cycle.
